// File: rtl/env_int_ctl.sv
// env_int_ctl: interrupt scheduler for the tv80 test environment.
// Owns a 7-register I/O window at BASE_ADDR. It counts down to schedule maskable INT
// requests (one-shot or periodic) and fixed-width NMI pulses. It also supplies the IM2
// vector on the interrupt-acknowledge cycle and counts acknowledges for firmware checks.
//
// INT FSM
//   state    | meaning
//   IDLE     | no request pending, int_n high
//   COUNT    | countdown running in icnt_q
//   ASSERT   | int_n held low until acknowledged or int_en cleared
//
// NMI FSM
//   state    | meaning
//   IDLE     | no pulse pending, nmi_n high
//   COUNT    | countdown running in ncnt_q
//   PULSE    | nmi_n low for NMI_PULSE clocks, reloads of NCNT ignored

module env_int_ctl #(
    parameter logic [7:0]  BASE_ADDR = 8'hA0,
    parameter int unsigned NMI_PULSE = 4,
    parameter logic [7:0]  VEC_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] addr,
    input  logic [7:0] DO,
    output logic [7:0] io_data,
    output logic       io_cs,
    output logic       int_n,
    output logic       nmi_n
);

    // Pulse counter must be able to hold NMI_PULSE itself.
    localparam int unsigned PW = (NMI_PULSE < 2) ? 1 : $clog2(NMI_PULSE + 1);
    localparam logic [PW-1:0] PULSE_LD  = PW'(NMI_PULSE);
    localparam logic [PW-1:0] PULSE_ONE = PW'(1);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_ICNT   = 3'd1;
    localparam logic [2:0] OFF_IRLD   = 3'd2;
    localparam logic [2:0] OFF_NCNT   = 3'd3;
    localparam logic [2:0] OFF_VECTOR = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_ACKCNT = 3'd6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_ASSERT = 2'd2;
    localparam logic [1:0] S_PULSE  = 2'd2;

    // Bus edge detectors
    logic       wr_q;
    logic       ack_q;

    // Configuration registers
    logic [2:0] ctrl_q,   ctrl_d;
    logic [7:0] irld_q,   irld_d;
    logic [7:0] vector_q, vector_d;
    logic [7:0] ackcnt_q, ackcnt_d;

    // INT scheduler
    logic [1:0] int_st_q, int_st_d;
    logic [7:0] icnt_q,   icnt_d;
    logic       int_n_q,  int_n_d;

    // NMI scheduler
    logic [1:0]    nmi_st_q, nmi_st_d;
    logic [7:0]    ncnt_q,   ncnt_d;
    logic [PW-1:0] pcnt_q,   pcnt_d;
    logic          nmi_n_q,  nmi_n_d;

    // Decode
    logic [7:0] offset;
    logic [2:0] reg_sel;
    logic       in_win;
    logic       wr_cond;
    logic       wr_evt;
    logic       rd_hit;
    logic       ack_raw;
    logic       ack_live;
    logic       ack_evt;
    logic       int_en;
    logic       nmi_en;
    logic       periodic;
    logic       wr_ctrl;
    logic       wr_icnt;
    logic       wr_irld;
    logic       wr_ncnt;
    logic       wr_vector;
    logic       wr_ackcnt;
    logic [7:0] rd_data;

    assign int_en   = ctrl_q[0];
    assign nmi_en   = ctrl_q[1];
    assign periodic = ctrl_q[2];

    // Address window and strobe decode; writes and acks act on the first cycle of the strobe only.
    always_comb begin
        offset    = addr - BASE_ADDR;
        in_win    = (offset < 8'd7);
        reg_sel   = offset[2:0];
        wr_cond   = ~iorq_n & ~wr_n & m1_n;
        wr_evt    = wr_cond & ~wr_q & in_win;
        rd_hit    = ~iorq_n & ~rd_n & m1_n & in_win;
        ack_raw   = ~m1_n & ~iorq_n;
        ack_live  = ack_raw & (int_st_q == S_ASSERT);
        // A write wins if it ever overlaps an acknowledge.
        ack_evt   = ack_live & ~ack_q & ~wr_evt;
        wr_ctrl   = wr_evt & (reg_sel == OFF_CTRL);
        wr_icnt   = wr_evt & (reg_sel == OFF_ICNT);
        wr_irld   = wr_evt & (reg_sel == OFF_IRLD);
        wr_ncnt   = wr_evt & (reg_sel == OFF_NCNT);
        wr_vector = wr_evt & (reg_sel == OFF_VECTOR);
        wr_ackcnt = wr_evt & (reg_sel == OFF_ACKCNT);
    end

    // Plain configuration registers and the saturating acknowledge counter.
    always_comb begin
        ctrl_d   = ctrl_q;
        irld_d   = irld_q;
        vector_d = vector_q;
        ackcnt_d = ackcnt_q;
        if (wr_ctrl) begin
            ctrl_d = DO[2:0];
        end
        if (wr_irld) begin
            irld_d = DO;
        end
        if (wr_vector) begin
            vector_d = DO;
        end
        if (wr_ackcnt) begin
            ackcnt_d = 8'h00;
        end else if (ack_evt && int_en && (ackcnt_q != 8'hFF)) begin
            ackcnt_d = ackcnt_q + 8'd1;
        end
    end

    // INT scheduler next state; an ICNT write re-arms from any state.
    always_comb begin
        int_st_d = int_st_q;
        icnt_d   = icnt_q;
        int_n_d  = int_n_q;
        case (int_st_q)
            S_IDLE: begin
                int_n_d = 1'b1;
            end
            S_COUNT: begin
                if (icnt_q <= 8'd1) begin
                    icnt_d = 8'h00;
                    if (int_en) begin
                        int_st_d = S_ASSERT;
                        int_n_d  = 1'b0;
                    end else begin
                        int_st_d = S_IDLE;
                    end
                end else begin
                    icnt_d = icnt_q - 8'd1;
                end
            end
            S_ASSERT: begin
                if (!int_en) begin
                    int_st_d = S_IDLE;
                    int_n_d  = 1'b1;
                end else if (ack_evt) begin
                    int_n_d = 1'b1;
                    if (periodic && (irld_q != 8'h00)) begin
                        int_st_d = S_COUNT;
                        icnt_d   = irld_q;
                    end else begin
                        int_st_d = S_IDLE;
                    end
                end
            end
            default: begin
                int_st_d = S_IDLE;
                int_n_d  = 1'b1;
            end
        endcase
        if (wr_icnt) begin
            icnt_d   = DO;
            int_n_d  = 1'b1;
            int_st_d = (DO == 8'h00) ? S_IDLE : S_COUNT;
        end
    end

    // NMI scheduler next state; a pulse in flight always runs to completion.
    always_comb begin
        nmi_st_d = nmi_st_q;
        ncnt_d   = ncnt_q;
        pcnt_d   = pcnt_q;
        nmi_n_d  = nmi_n_q;
        case (nmi_st_q)
            S_IDLE: begin
                nmi_n_d = 1'b1;
            end
            S_COUNT: begin
                if (ncnt_q <= 8'd1) begin
                    ncnt_d = 8'h00;
                    if (nmi_en) begin
                        nmi_st_d = S_PULSE;
                        nmi_n_d  = 1'b0;
                        pcnt_d   = PULSE_LD;
                    end else begin
                        nmi_st_d = S_IDLE;
                    end
                end else begin
                    ncnt_d = ncnt_q - 8'd1;
                end
            end
            S_PULSE: begin
                if (pcnt_q <= PULSE_ONE) begin
                    pcnt_d   = '0;
                    nmi_n_d  = 1'b1;
                    nmi_st_d = S_IDLE;
                end else begin
                    pcnt_d = pcnt_q - PULSE_ONE;
                end
            end
            default: begin
                nmi_st_d = S_IDLE;
                nmi_n_d  = 1'b1;
            end
        endcase
        if (wr_ncnt && (nmi_st_q != S_PULSE)) begin
            ncnt_d   = DO;
            nmi_n_d  = 1'b1;
            nmi_st_d = (DO == 8'h00) ? S_IDLE : S_COUNT;
        end
    end

    // Register readback mux.
    always_comb begin
        case (reg_sel)
            OFF_CTRL:   rd_data = {5'b00000, ctrl_q};
            OFF_ICNT:   rd_data = icnt_q;
            OFF_IRLD:   rd_data = irld_q;
            OFF_NCNT:   rd_data = ncnt_q;
            OFF_VECTOR: rd_data = vector_q;
            OFF_STATUS: rd_data = {6'b000000, ~nmi_n_q, ~int_n_q};
            OFF_ACKCNT: rd_data = ackcnt_q;
            default:    rd_data = 8'h00;
        endcase
    end

    // Bus data: the acknowledge vector takes precedence over register reads.
    always_comb begin
        io_cs   = ack_live | rd_hit;
        io_data = 8'h00;
        if (ack_live) begin
            io_data = vector_q;
        end else if (rd_hit) begin
            io_data = rd_data;
        end
    end

    // Strobe history for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q  <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            wr_q  <= wr_cond;
            ack_q <= ack_raw;
        end
    end

    // Configuration register state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q   <= 3'b000;
            irld_q   <= 8'h00;
            vector_q <= VEC_RESET;
            ackcnt_q <= 8'h00;
        end else begin
            ctrl_q   <= ctrl_d;
            irld_q   <= irld_d;
            vector_q <= vector_d;
            ackcnt_q <= ackcnt_d;
        end
    end

    // INT scheduler state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_st_q <= S_IDLE;
            icnt_q   <= 8'h00;
            int_n_q  <= 1'b1;
        end else begin
            int_st_q <= int_st_d;
            icnt_q   <= icnt_d;
            int_n_q  <= int_n_d;
        end
    end

    // NMI scheduler state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nmi_st_q <= S_IDLE;
            ncnt_q   <= 8'h00;
            pcnt_q   <= '0;
            nmi_n_q  <= 1'b1;
        end else begin
            nmi_st_q <= nmi_st_d;
            ncnt_q   <= ncnt_d;
            pcnt_q   <= pcnt_d;
            nmi_n_q  <= nmi_n_d;
        end
    end

    assign int_n = int_n_q;
    assign nmi_n = nmi_n_q;

endmodule

// File: tb/tb_env_int_ctl.sv
// Directed bench for env_int_ctl: expected values are queued as each stimulus step is
// driven and popped when the corresponding DUT output is sampled (at/after negedge).
module tb_env_int_ctl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       m1_n;
    logic [7:0] addr;
    logic [7:0] DO;
    logic [7:0] io_data;
    logic       io_cs;
    logic       int_n;
    logic       nmi_n;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    env_int_ctl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .iorq_n  (iorq_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .m1_n    (m1_n),
        .addr    (addr),
        .DO      (DO),
        .io_data (io_data),
        .io_cs   (io_cs),
        .int_n   (int_n),
        .nmi_n   (nmi_n)
    );

    always #5 clk = ~clk;

    task automatic expect_push(input logic [8:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [8:0] obs);
        logic [8:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic pin(input string tag, input logic e, input logic o);
        expect_push({8'h00, e});
        chk(tag, {8'h00, o});
    endtask

    task automatic bus_idle();
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
    endtask

    // Starts at a negedge; write edge W is the next posedge; returns at the negedge after W+1.
    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr   = a;
        DO     = d;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic io_read(input string tag, input logic [7:0] a, input logic cs, input logic [7:0] d);
        expect_push({cs, d});
        addr   = a;
        iorq_n = 1'b0;
        rd_n   = 1'b0;
        #2;
        chk(tag, {io_cs, io_data});
        bus_idle();
        @(negedge clk);
    endtask

    // Returns at the negedge right after the acknowledge edge.
    task automatic int_ack(input string tag, input logic [7:0] vec);
        expect_push({1'b1, vec});
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        #2;
        chk(tag, {io_cs, io_data});
        @(posedge clk);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wait_int_low(input string tag);
        int n = 0;
        while (int_n !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        pin(tag, 1'b0, int_n);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0;
        addr    = 8'h00;
        DO      = 8'h00;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values
        pin("rst_int_n", 1'b1, int_n);
        pin("rst_nmi_n", 1'b1, nmi_n);
        io_read("rst_ctrl",   8'hA0, 1'b1, 8'h00);
        io_read("rst_icnt",   8'hA1, 1'b1, 8'h00);
        io_read("rst_irld",   8'hA2, 1'b1, 8'h00);
        io_read("rst_ncnt",   8'hA3, 1'b1, 8'h00);
        io_read("rst_vector", 8'hA4, 1'b1, 8'hFF);
        io_read("rst_status", 8'hA5, 1'b1, 8'h00);
        io_read("rst_ackcnt", 8'hA6, 1'b1, 8'h00);
        io_read("out_win_hi", 8'hA7, 1'b0, 8'h00);
        io_read("out_win_lo", 8'h9F, 1'b0, 8'h00);

        // One-shot INT after 5 clocks
        io_write(8'hA0, 8'h01);
        io_write(8'hA1, 8'h05);
        for (int i = 1; i <= 5; i++) begin
            pin($sformatf("oneshot_int_n_t%0d", i), (i == 5) ? 1'b0 : 1'b1, int_n);
            if (i < 5) @(negedge clk);
        end
        io_read("oneshot_status", 8'hA5, 1'b1, 8'h01);
        int_ack("oneshot_vec", 8'hFF);
        pin("oneshot_int_release", 1'b1, int_n);
        io_read("oneshot_ackcnt", 8'hA6, 1'b1, 8'h01);
        io_read("oneshot_icnt", 8'hA1, 1'b1, 8'h00);

        // Periodic INT, reload 3, vector 40
        io_write(8'hA0, 8'h05);
        io_write(8'hA2, 8'h03);
        io_write(8'hA4, 8'h40);
        io_write(8'hA6, 8'h00);
        io_write(8'hA1, 8'h02);
        pin("per_first_t1", 1'b1, int_n);
        @(negedge clk);
        pin("per_first_t2", 1'b0, int_n);
        for (int k = 0; k < 3; k++) begin
            int_ack($sformatf("per_vec_%0d", k), 8'h40);
            pin($sformatf("per_release_%0d", k), 1'b1, int_n);
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                pin($sformatf("per_refall_%0d_t%0d", k, i), (i == 3) ? 1'b0 : 1'b1, int_n);
            end
        end
        io_read("per_ackcnt", 8'hA6, 1'b1, 8'h03);
        io_read("per_ctrl", 8'hA0, 1'b1, 8'h05);

        // Disabling INT while asserted drops the request without counting an ack
        io_write(8'hA0, 8'h00);
        pin("dis_int_release", 1'b1, int_n);
        io_read("dis_ackcnt", 8'hA6, 1'b1, 8'h03);
        io_read("dis_status", 8'hA5, 1'b1, 8'h00);

        // NMI pulse: low 4..7 clocks after the NCNT write, a reload during the pulse is ignored
        io_write(8'hA0, 8'h02);
        io_write(8'hA3, 8'h04);
        pin("nmi_t1", 1'b1, nmi_n);
        @(negedge clk);
        pin("nmi_t2", 1'b1, nmi_n);
        @(negedge clk);
        pin("nmi_t3", 1'b1, nmi_n);
        @(negedge clk);
        pin("nmi_t4", 1'b0, nmi_n);
        io_write(8'hA3, 8'h09);
        pin("nmi_t6", 1'b0, nmi_n);
        @(negedge clk);
        io_read("nmi_status_t7", 8'hA5, 1'b1, 8'h02);
        pin("nmi_t8", 1'b1, nmi_n);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (nmi_n === 1'b0) seen = 1'b1;
        end
        pin("nmi_not_extended", 1'b0, seen);
        io_read("nmi_ncnt_after", 8'hA3, 1'b1, 8'h00);

        // ICNT=0 while counting cancels the request
        io_write(8'hA0, 8'h01);
        io_write(8'hA1, 8'h04);
        io_write(8'hA1, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (int_n === 1'b0) seen = 1'b1;
        end
        pin("icnt0_cancel", 1'b0, seen);
        io_read("icnt0_icnt", 8'hA1, 1'b1, 8'h00);

        // ACKCNT saturation over 300 acknowledges
        io_write(8'hA0, 8'h05);
        io_write(8'hA2, 8'h01);
        io_write(8'hA6, 8'h00);
        io_write(8'hA1, 8'h01);
        for (int k = 0; k < 300; k++) begin
            wait_int_low($sformatf("sat_wait_%0d", k));
            int_ack($sformatf("sat_vec_%0d", k), 8'h40);
        end
        io_write(8'hA0, 8'h00);
        pin("sat_int_release", 1'b1, int_n);
        io_read("sat_ackcnt", 8'hA6, 1'b1, 8'hFF);

        // Write strobe held for three clocks loads ICNT once
        io_write(8'hA0, 8'h01);
        io_write(8'hA6, 8'h00);
        io_read("ackcnt_cleared", 8'hA6, 1'b1, 8'h00);
        addr   = 8'hA1;
        DO     = 8'h02;
        iorq_n = 1'b0;
        wr_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_idle();
        pin("held_wr_single_load", 1'b0, int_n);
        int_ack("held_wr_vec", 8'h40);
        pin("held_wr_release", 1'b1, int_n);
        io_read("held_wr_ackcnt", 8'hA6, 1'b1, 8'h01);

        // Reset in the middle of a countdown
        io_write(8'hA1, 8'h05);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (int_n === 1'b0) seen = 1'b1;
        end
        pin("midrst_no_int", 1'b0, seen);
        io_read("midrst_ctrl",   8'hA0, 1'b1, 8'h00);
        io_read("midrst_icnt",   8'hA1, 1'b1, 8'h00);
        io_read("midrst_vector", 8'hA4, 1'b1, 8'hFF);
        io_read("midrst_ackcnt", 8'hA6, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
